// File: rtl/register_dump_reader.sv
// register_dump_reader: walks the register bank in index order after a start
// pulse and streams each word MSB-byte-first over a valid/ready byte port.
// Optional trailing XOR checksum byte when REG_DUMP_CHECKSUM_EN is defined.
// Ports: i_clock, i_reset_n (async, active-low), i_start, i_abort,
//   o_reg_sel/o_reg_read_valid/i_reg_data (bank read port),
//   o_tx_data/o_tx_valid/i_tx_ready (byte stream), o_busy, o_done.
module register_dump_reader #(
    parameter int NB_DATA     = 32,
    parameter int N_REGISTERS = 32,
    parameter int NB_REGISTER = 5,
    parameter int NB_BYTE     = 8
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_start,
    input  logic                   i_abort,
    output logic [NB_REGISTER-1:0] o_reg_sel,
    output logic                   o_reg_read_valid,
    input  logic [NB_DATA-1:0]     i_reg_data,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int BPR    = NB_DATA / NB_BYTE;
    localparam int NB_CNT = (BPR > 1) ? $clog2(BPR) : 1;

    localparam logic [NB_CNT-1:0]      LAST_BYTE = NB_CNT'(BPR - 1);
    localparam logic [NB_REGISTER-1:0] LAST_REG  = NB_REGISTER'(N_REGISTERS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_SEND, S_CHKSUM, S_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_READ, S_SEND, S_DONE
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [NB_REGISTER-1:0] reg_idx_q, reg_idx_d;
    logic [NB_CNT-1:0]      byte_cnt_q, byte_cnt_d;
    logic [NB_DATA-1:0]     buf_q, buf_d;
    logic [NB_BYTE-1:0]     head_byte;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0]     csum_q, csum_d;
`endif

    assign head_byte = buf_q[NB_DATA-1 -: NB_BYTE];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            reg_idx_q  <= '0;
            byte_cnt_q <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            reg_idx_q  <= reg_idx_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_comb begin
        state_d          = state_q;
        reg_idx_d        = reg_idx_q;
        byte_cnt_d       = byte_cnt_q;
        buf_d            = buf_q;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d           = csum_q;
`endif
        o_reg_sel        = '0;
        o_reg_read_valid = 1'b0;
        o_tx_data        = '0;
        o_tx_valid       = 1'b0;
        o_busy           = 1'b0;
        o_done           = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_READ;
                    reg_idx_d  = '0;
                    byte_cnt_d = '0;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            S_READ: begin
                o_busy           = 1'b1;
                o_reg_sel        = reg_idx_q;
                o_reg_read_valid = 1'b1;
                buf_d            = i_reg_data;
                byte_cnt_d       = '0;
                state_d          = S_SEND;
            end
            S_SEND: begin
                o_busy     = 1'b1;
                o_tx_valid = 1'b1;
                o_tx_data  = head_byte;
                if (i_tx_ready) begin
                    buf_d      = buf_q << NB_BYTE;
                    byte_cnt_d = byte_cnt_q + NB_CNT'(1);
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d     = csum_q ^ head_byte;
`endif
                    if (byte_cnt_q == LAST_BYTE) begin
                        // terminal compares end the walk; no wrap
                        if (reg_idx_q == LAST_REG) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            state_d = S_CHKSUM;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            reg_idx_d = reg_idx_q + NB_REGISTER'(1);
                            state_d   = S_READ;
                        end
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            S_CHKSUM: begin
                o_busy     = 1'b1;
                o_tx_valid = 1'b1;
                o_tx_data  = csum_q;
                if (i_tx_ready) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                o_busy     = 1'b1;
                o_done     = 1'b1;
                reg_idx_d  = '0;
                byte_cnt_d = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort overrides every transition, including a start from idle
        if (i_abort) begin
            state_d    = S_IDLE;
            reg_idx_d  = '0;
            byte_cnt_d = '0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_d     = '0;
`endif
        end
    end

endmodule

// File: tb/tb_register_dump_reader.sv
// tb_register_dump_reader: randomized bench for register_dump_reader with a
// queue-based model of the expected byte stream built from the bank image.
module tb_register_dump_reader;

    localparam int NR  = 32;
    localparam int BPR = 4;
    localparam int NBYTES = NR * BPR;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  reg_sel;
    logic        reg_rv;
    logic [31:0] reg_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        done;

    logic [31:0] bank [NR];

    int errors = 0;
    int checks = 0;

    byte unsigned got [$];
    byte unsigned exp_q [$];
    int read_first, first_valid, done_cyc, done_cnt, busy_after;
    int stab_err, sel_err, reads, timed_out;
    int post_valid, post_busy, post_done;

    always #5 clk = ~clk;

    assign reg_data = bank[reg_sel];

    register_dump_reader dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_start          (start),
        .i_abort          (abort),
        .o_reg_sel        (reg_sel),
        .o_reg_read_valid (reg_rv),
        .i_reg_data       (reg_data),
        .o_tx_data        (tx_data),
        .o_tx_valid       (tx_valid),
        .i_tx_ready       (tx_ready),
        .o_busy           (busy),
        .o_done           (done)
    );

    // Model: registers in index order, each word most significant byte first.
    task automatic build_expected();
        byte unsigned x;
        x = 0;
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            for (int b = BPR - 1; b >= 0; b--) begin
                exp_q.push_back(byte'((bank[i] >> (8 * b)) & 32'hFF));
                x = x ^ byte'((bank[i] >> (8 * b)) & 32'hFF);
            end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Drives one dump and records what the DUT did; checks live in the tests.
    task automatic collect(input int mode, input int abort_at,
                           input int restart_at);
        bit prev_hold, aborted, restarted, fin;
        logic [7:0] prev_data;
        int abort_cyc;
        got.delete();
        read_first = -1; first_valid = -1; done_cyc = -1; done_cnt = 0;
        busy_after = -1; stab_err = 0; sel_err = 0; reads = 0;
        timed_out = 0; post_valid = -1; post_busy = -1; post_done = -1;
        prev_hold = 0; prev_data = '0; aborted = 0; restarted = 0;
        fin = 0; abort_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        tx_ready = 1'b0;
        for (int c = 1; c < 4000; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (aborted && c == abort_cyc + 1) begin
                post_valid = int'(tx_valid);
                post_busy  = int'(busy);
                post_done  = int'(done);
                fin = 1;
                break;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                busy_after = int'(busy);
                fin = 1;
                break;
            end
            if (restart_at >= 0 && !restarted && got.size() == restart_at) begin
                start = 1'b1;
                restarted = 1;
            end
            if (reg_rv) begin
                if (read_first < 0) read_first = c;
                if (reg_sel != 5'(reads)) sel_err++;
                reads++;
            end
            if (tx_valid && first_valid < 0) first_valid = c;
            if (prev_hold && (!tx_valid || tx_data != prev_data)) stab_err++;
            case (mode)
                0: tx_ready = 1'b1;
                1: tx_ready = ($urandom_range(0, 2) == 0);
                default: tx_ready = 1'($urandom);
            endcase
            if (abort_at >= 0 && !aborted && got.size() == abort_at) begin
                abort = 1'b1;
                aborted = 1;
                abort_cyc = c;
            end
            if (tx_valid && tx_ready) got.push_back(tx_data);
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        if (!fin) timed_out = 1;
        start = 1'b0;
        abort = 1'b0;
        tx_ready = 1'b0;
    endtask

    task automatic check_stream(input string name);
        int bad;
        bad = -1;
        checks++;
        if (timed_out != 0) begin
            errors++;
            $display("FAIL %s timeout: dump did not finish in budget", name);
        end
        checks++;
        if (got.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s length: got %0d bytes, expected %0d",
                     name, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (bad < 0 && got[i] != exp_q[i]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s data: byte %0d got %02h expected %02h",
                     name, bad, got[bad], exp_q[bad]);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s done pulses: got %0d expected 1", name, done_cnt);
        end
        checks++;
        if (sel_err !== 0 || reads !== NR) begin
            errors++;
            $display("FAIL %s reg_sel: %0d bad selects, %0d reads, expected 0 and %0d",
                     name, sel_err, reads, NR);
        end
        checks++;
        if (busy_after !== 0) begin
            errors++;
            $display("FAIL %s busy after done: got %0d expected 0", name, busy_after);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({busy, tx_valid, done, reg_rv, reg_sel, tx_data} !== 17'h0) begin
            errors++;
            $display("FAIL reset outputs: got b=%b v=%b d=%b rv=%b sel=%0d data=%02h expected all 0",
                     busy, tx_valid, done, reg_rv, reg_sel, tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset idle: got busy=%b valid=%b expected 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_full_dump();
        for (int i = 0; i < NR; i++) bank[i] = 32'h01020300 + 32'(i);
        bank[0] = 32'h0;
        build_expected();
        collect(0, -1, -1);
        check_stream("full_dump");
        checks++;
        if (read_first !== 1) begin
            errors++;
            $display("FAIL latency read: got cycle %0d expected 1", read_first);
        end
        checks++;
        if (first_valid !== 2) begin
            errors++;
            $display("FAIL latency first byte: got cycle %0d expected 2", first_valid);
        end
        checks++;
        if (done_cyc - read_first !== NR * (1 + BPR) + (exp_q.size() - NBYTES)) begin
            errors++;
            $display("FAIL done timing: got %0d cycles expected %0d",
                     done_cyc - read_first, NR * (1 + BPR) + (exp_q.size() - NBYTES));
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < NR; i++) bank[i] = 32'h01020300 + 32'(i);
        bank[0] = 32'h0;
        build_expected();
        collect(1, -1, -1);
        check_stream("bp_one_in_three");
        checks++;
        if (stab_err !== 0) begin
            errors++;
            $display("FAIL bp stability: got %0d unstable cycles expected 0", stab_err);
        end
        for (int i = 0; i < NR; i++) bank[i] = $urandom;
        build_expected();
        collect(2, -1, -1);
        check_stream("bp_random");
        checks++;
        if (stab_err !== 0) begin
            errors++;
            $display("FAIL bp_random stability: got %0d unstable cycles expected 0", stab_err);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < NR; i++) bank[i] = $urandom;
        build_expected();
        collect(0, 10, -1);
        checks++;
        if (post_valid !== 0 || post_busy !== 0 || post_done !== 0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL abort: got valid=%0d busy=%0d done=%0d pulses=%0d expected 0 0 0 0",
                     post_valid, post_busy, post_done, done_cnt);
        end
        collect(2, -1, -1);
        check_stream("after_abort");
    endtask

    task automatic test_start_while_busy();
        for (int i = 0; i < NR; i++) bank[i] = $urandom;
        build_expected();
        collect(2, -1, 50);
        check_stream("restart_ignored");
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        for (int i = 0; i < NR; i++) bank[i] = $urandom;
        @(negedge clk);
        start = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, tx_valid, done, reg_rv, reg_sel, tx_data} !== 17'h0) begin
            errors++;
            $display("FAIL async reset: got b=%b v=%b d=%b rv=%b sel=%0d data=%02h expected all 0",
                     busy, tx_valid, done, reg_rv, reg_sel, tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (busy || tx_valid || done || reg_rv) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL post reset idle: got %0d active cycles expected 0", n);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_start_abort_idle();
        int n;
        n = 0;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (busy || reg_rv || tx_valid) n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL start_abort_idle: got %0d busy cycles expected 0", n);
        end
    endtask

`ifdef REG_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < NR; i++) bank[i] = 32'hFFFFFFFF;
        bank[0] = 32'h0;
        build_expected();
        collect(2, -1, -1);
        check_stream("checksum_ff");
        checks++;
        if (got.size() != NBYTES + 1 || got[NBYTES] != 8'h00) begin
            errors++;
            $display("FAIL checksum_ff byte: got %0d bytes, last %02h expected 129 and 00",
                     got.size(), got.size() > 0 ? got[got.size() - 1] : 8'h00);
        end
        bank[1] = 32'h000000A5;
        build_expected();
        collect(1, -1, -1);
        check_stream("checksum_a5");
    endtask
`endif

    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_abort();
        test_start_while_busy();
        test_start_abort_idle();
        test_async_reset();
`ifdef REG_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
